// File: rtl/ym2413_opll_lite_tt.sv
// Reduced YM2413 (OPLL)-style tone generator for a TinyTapeout tile.
// Nibble-serial register writes, nine square-wave channels summed into a
// 16-bit signed sample on {uo_out, uio_out}.
// Optional build macro OPLL_RHYTHM_MUTE_EN: reg 0x0E bit5 mutes channels 6-8.
module ym2413_opll_lite_tt #(
  parameter int unsigned CLKS_PER_SAMPLE = 72,
  parameter int unsigned NUM_CH          = 9,
  parameter int unsigned AMP_STEP        = 136
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_SAMPLE - 1);

  // Write decoder state
  logic       wr_q, wr_d;
  logic [3:0] nib_q, nib_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rhythm_q, rhythm_d;
  logic [7:0] fnum_lo_q [NUM_CH];
  logic [7:0] fnum_lo_d [NUM_CH];
  logic [5:0] ctrl_q    [NUM_CH];  // sustain, key, block[2:0], fnum[8]
  logic [5:0] ctrl_d    [NUM_CH];
  logic [7:0] vol_q     [NUM_CH];  // instrument[7:4], attenuation[3:0]
  logic [7:0] vol_d     [NUM_CH];

  // Sample engine state
  logic [18:0]        phase_q [NUM_CH];
  logic [18:0]        phase_d [NUM_CH];
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic signed [15:0] acc_q, acc_d;
  logic [15:0]        sample_q, sample_d;

  logic [7:0]         wbyte;
  logic               wr_rise;
  logic [15:0]        inc;
  logic [10:0]        amp;
  logic signed [15:0] contrib;
  logic               mute;
  logic               unused_bits;

  assign wr_rise = ena & ui_in[6] & ~wr_q;
  assign wbyte   = {ui_in[3:0], nib_q};

  // Register-map write decode on the rising edge of the WR strobe
  always_comb begin
    wr_d      = ena ? ui_in[6] : wr_q;
    nib_d     = nib_q;
    addr_d    = addr_q;
    rhythm_d  = rhythm_q;
    fnum_lo_d = fnum_lo_q;
    ctrl_d    = ctrl_q;
    vol_d     = vol_q;
    if (wr_rise) begin
      if (!ui_in[4]) begin
        nib_d = ui_in[3:0];
      end else if (!ui_in[5]) begin
        addr_d = wbyte;
      end else if (addr_q == 8'h0E) begin
        rhythm_d = wbyte;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (addr_q[3:0] == 4'(i)) begin
            case (addr_q[7:4])
              4'h1:    fnum_lo_d[i] = wbyte;
              4'h2:    ctrl_d[i]    = wbyte[5:0];
              4'h3:    vol_d[i]     = wbyte;
              default: ;
            endcase
          end
        end
      end
    end
  end

  // One channel per slot for c = 0..NUM_CH-1, sample latch at the last slot
  always_comb begin
    phase_d  = phase_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    inc      = '0;
    amp      = '0;
    contrib  = '0;
    mute     = 1'b0;
    if (ena) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_q == CntW'(i)) begin
          inc = 16'({ctrl_q[i][0], fnum_lo_q[i]}) << ctrl_q[i][3:1];
          amp = 11'(4'd15 - vol_q[i][3:0]) * 11'(AMP_STEP);
`ifdef OPLL_RHYTHM_MUTE_EN
          mute = rhythm_q[5] && (i >= 6);
`else
          mute = 1'b0;
`endif
          if (ctrl_q[i][4] && !mute) begin
            // Sign taken from the phase before this slot's advance
            contrib    = phase_q[i][18] ? -$signed({5'd0, amp}) : $signed({5'd0, amp});
            phase_d[i] = phase_q[i] + 19'(inc);
          end else begin
            phase_d[i] = '0;
          end
          acc_d = acc_q + contrib;
        end
      end
      if (cnt_q == CntLast) begin
        sample_d = acc_q;
        acc_d    = '0;
      end
    end
  end

  // Stored-but-unused register bits and unused inputs
  always_comb begin
    unused_bits = ^{uio_in, ui_in[7], rhythm_q};
    for (int i = 0; i < NUM_CH; i++) begin
      unused_bits = unused_bits ^ (^{ctrl_q[i][5], vol_q[i][7:4]});
    end
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      nib_q    <= '0;
      addr_q   <= '0;
      rhythm_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        fnum_lo_q[i] <= '0;
        ctrl_q[i]    <= '0;
        vol_q[i]     <= '0;
        phase_q[i]   <= '0;
      end
    end else begin
      wr_q      <= wr_d;
      nib_q     <= nib_d;
      addr_q    <= addr_d;
      rhythm_q  <= rhythm_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      fnum_lo_q <= fnum_lo_d;
      ctrl_q    <= ctrl_d;
      vol_q     <= vol_d;
      phase_q   <= phase_d;
    end
  end

  assign uo_out  = sample_q[15:8];
  assign uio_out = sample_q[7:0];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_ym2413_opll_lite_tt.sv
// Scoreboard bench for ym2413_opll_lite_tt: expected samples are queued when
// stimulus is applied and compared at each sample boundary.
module tb_ym2413_opll_lite_tt;

  localparam int Clks = 72;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;
  int bc;
  event sample_ev;

  typedef struct {
    string       tag;
    logic [15:0] val;
    bit          skip;
    bit          absm;
  } sb_t;
  sb_t sb_q[$];

  ym2413_opll_lite_tt dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bench-side sample counter: boundary is the edge that handles slot Clks-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc <= 0;
    end else if (ena) begin
      if (bc == Clks - 1) begin
        bc <= 0;
        ->sample_ev;
      end else begin
        bc <= bc + 1;
      end
    end
  end

  // Pop one expectation per produced sample
  initial begin
    sb_t         e;
    logic [15:0] obs;
    forever begin
      @(sample_ev);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (!e.skip) begin
          obs = {uo_out, uio_out};
          if (e.absm && obs[15]) obs = -obs;
          check_eq(e.tag, 32'(obs), 32'(e.val));
        end
      end
    end
  end

  task automatic push(input string tag, input logic [15:0] val, input int n,
                      input bit skip = 1'b0, input bit absm = 1'b0);
    sb_t e;
    e.tag = tag; e.val = val; e.skip = skip; e.absm = absm;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    if (sb_q.size() != 0) begin
      check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  // Align to just after a sample boundary, before slot 0 is processed
  task automatic gap();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * Clks && !found; i++) begin
      @(posedge clk);
      #1;
      if (bc == 0) found = 1'b1;
    end
    if (!found) check_eq("gap_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wr_nib(input bit a0, input bit hi, input logic [3:0] nib);
    ui_in = {1'b0, 1'b1, a0, hi, nib};
    @(negedge clk);
    ui_in[6] = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    wr_nib(1'b0, 1'b0, addr[3:0]);
    wr_nib(1'b0, 1'b1, addr[7:4]);
    wr_nib(1'b1, 1'b0, data[3:0]);
    wr_nib(1'b1, 1'b1, data[7:4]);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_oe", 32'(uio_oe), 32'hFF);
    check_eq("rst_out", 32'({uo_out, uio_out}), 32'h0);
    rst_n = 1'b1;

    // Idle after reset
    push("idle", 16'h0000, 6);
    drain();
    repeat (70) @(negedge clk);
    check_eq("idle_oe", 32'(uio_oe), 32'hFF);

    // Channel 0 tone: inc 4096, 128-sample period
    gap();
    push("tone_lat", 16'h0, 1, 1'b1);
    push("tone_pos", 16'h07F8, 64);
    push("tone_neg", 16'hF808, 64);
    push("tone_pos2", 16'h07F8, 2);
    write_reg(8'h10, 8'h00);
    write_reg(8'h20, 8'h19);
    write_reg(8'h30, 8'h00);
    drain();

    // Volume: max attenuation silences, 7 gives 8 * 136
    gap();
    push("vol_lat", 16'h0, 1, 1'b1);
    push("vol_f", 16'h0000, 3);
    write_reg(8'h30, 8'h0F);
    drain();
    gap();
    push("vol_lat", 16'h0, 1, 1'b1);
    push("vol_7", 16'd1088, 3, 1'b0, 1'b1);
    write_reg(8'h30, 8'h07);
    drain();

    // Key-off silences; re-key restarts from phase 0
    gap();
    push("koff_lat", 16'h0, 1, 1'b1);
    push("koff", 16'h0000, 3);
    write_reg(8'h20, 8'h08);
    drain();
    gap();
    push("rekey_lat", 16'h0, 1, 1'b1);
    push("rekey", 16'h07F8, 2);
    write_reg(8'h30, 8'h00);
    write_reg(8'h20, 8'h19);
    drain();

    // Nine channels, identical tone: full-scale sum without wrap
    gap();
    push("all_lat", 16'h0, 1, 1'b1);
    write_reg(8'h20, 8'h08);
    drain();
    gap();
    push("all_lat", 16'h0, 3, 1'b1);
    push("all_pos", 16'h47B8, 62);
    push("all_edge", 16'h0, 2, 1'b1);
    push("all_neg", 16'hB848, 62);
    for (int n = 0; n < 9; n++) write_reg(8'h20 + 8'(n), 8'h19);
    drain();

    // Asynchronous reset mid-sample
    gap();
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", 32'({uo_out, uio_out}), 32'h0);
    check_eq("async_oe", 32'(uio_oe), 32'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // WR held high for 20 cycles commits only once (key-off, then nibble flips)
    gap();
    push("hold_lat", 16'h0, 1, 1'b1);
    push("hold_wr", 16'h0000, 3);
    wr_nib(1'b0, 1'b0, 4'h0);
    wr_nib(1'b0, 1'b1, 4'h2);
    wr_nib(1'b1, 1'b0, 4'h8);
    ui_in = 8'b0111_0000;
    repeat (2) @(negedge clk);
    ui_in[3:0] = 4'h1;
    repeat (18) @(negedge clk);
    ui_in = 8'h00;
    @(negedge clk);
    drain();

    // Key ch0, then writes to unmapped addresses change nothing
    gap();
    push("key_lat", 16'h0, 1, 1'b1);
    push("key_on", 16'h07F8, 3);
    write_reg(8'h20, 8'h19);
    drain();
    gap();
    push("unmapped", 16'h07F8, 3);
    write_reg(8'h19, 8'hFF);
    write_reg(8'h40, 8'h00);
    drain();

    // ena low: writes ignored, output holds
    gap();
    ena = 1'b0;
    write_reg(8'h30, 8'h0F);
    write_reg(8'h20, 8'h08);
    repeat (100) @(negedge clk);
    check_eq("ena_hold", 32'({uo_out, uio_out}), 32'h07F8);
    ena = 1'b1;
    push("ena_ignored", 16'h07F8, 2);
    drain();

    // Rhythm register: mutes channel 6 only when the option is built in
    gap();
    push("rhy_lat", 16'h0, 1, 1'b1);
`ifdef OPLL_RHYTHM_MUTE_EN
    push("rhy_mute", 16'h0000, 3);
`else
    push("rhy_melodic", 16'h07F8, 3);
`endif
    write_reg(8'h20, 8'h08);
    write_reg(8'h0E, 8'h20);
    write_reg(8'h26, 8'h19);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
